fft_bitrev_loader: RTL and testbench
====================================

FFT_BITREV_LOADER -- requirements
Module: fft_bitrev_loader

Interface
REQ-001 Parameter N, default 64, FFT points per frame, power of two, 8..1024.
REQ-002 Parameter LOG2N, default 6, log2(N).
REQ-003 Parameter WIDTH, default 32, packed complex word {real[WIDTH-1:WIDTH/2], imag[WIDTH/2-1:0]}, each half signed Q1.15.
REQ-004 clk  in  1  sole clock, all state rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 sample_valid  in  1  audio sample present.
REQ-007 sample_in  in  WIDTH/2  signed Q1.15 audio sample.
REQ-008 sample_ready  out  1  loader accepts sample this cycle.
REQ-009 frame_valid  out  1  bank rd_bank holds a complete frame.
REQ-010 rd_addr  in  LOG2N  FFT engine read address.
REQ-011 rd_data  out  WIDTH  packed word from bank rd_bank at rd_addr.
REQ-012 frame_done  in  1  one-cycle pulse, FFT engine releases current frame.
REQ-013 overrun  out  1  one-cycle pulse, sample dropped.
REQ-014 drop_count  out  16  saturating count of dropped samples.

Function
REQ-015 Two banks of N words (ping-pong); per-bank full flag; write pointer wr_bank; read pointer rd_bank.
REQ-016 Sample accepted iff sample_valid && sample_ready; written to bank wr_bank at address bitrev(cnt), word {sample_in, 16'h0000}; cnt increments.
REQ-017 bitrev reverses the LOG2N bits of cnt (LOG2N=6: cnt 1 -> addr 32, cnt 6 -> addr 24).
REQ-018 Writer FSM states FILL, STALL; sample_ready = 1 in FILL, 0 in STALL and during rst.
REQ-019 FILL, accept at cnt=N-1: set full[wr_bank], cnt wraps to 0; if full[~wr_bank]=0, or frame_done clears it this cycle, toggle wr_bank, stay FILL; else go STALL.
REQ-020 STALL: when full[~wr_bank] is 0 or cleared this cycle, toggle wr_bank, go FILL.
REQ-021 frame_valid = full[rd_bank].
REQ-022 frame_done with frame_valid=1 clears full[rd_bank] and toggles rd_bank next cycle; frame_done with frame_valid=0 ignored.
REQ-023 rd_data registered: 1-cycle latency from rd_addr; reads valid only while frame_valid=1; rd_bank switches after frame_done effective next cycle.
REQ-024 sample_valid && !sample_ready (not in rst): sample discarded, no memory write, overrun pulses 1 cycle, drop_count +1 saturating at 16'hFFFF.
REQ-025 Bank set-full and same-bank clear cannot coincide (writer never owns rd_bank while full); frame_done and frame completion in same cycle both take effect.
REQ-026 No arithmetic on samples; imaginary half always zero.

Reset
REQ-027 rst: cnt=0, wr_bank=0, rd_bank=0, full=2'b00, FSM=FILL, frame_valid=0, rd_data=0, overrun=0, drop_count=0.
REQ-028 rst mid-frame abandons partial and full frames; memory contents not reset, not relied upon.

Structure
REQ-029 Shared package fft_pkg: N, LOG2N, WIDTH, sample/complex typedefs, pack function, bitrev function (reused by FFT address generator).
REQ-030 One sub-module fft_frame_ram: simple dual-port RAM, 1 write port, 1 registered read port, 2*N x WIDTH, address {bank, addr}.

Verification
REQ-031 Reset then 64 samples value k (k=0..63), no gaps -> frame_valid=1 after last accept; rd_addr=32 gives 32'h0001_0000, rd_addr=1 gives 32'h0020_0000 next cycle.
REQ-032 Continue 64 more samples without frame_done -> bank1 fills, sample_ready=0 thereafter; 3 extra valid samples -> 3 overrun pulses, drop_count=3.
REQ-033 frame_done in STALL -> rd_bank=1, frame_valid stays 1, sample_ready=1 next cycle, bank0 refills.
REQ-034 64th sample accepted same cycle as frame_done with other bank full -> no STALL, sample_ready stays 1, wr_bank toggles.
REQ-035 rst asserted at cnt=40 -> frame_valid=0, drop_count=0, next accepted sample written to addr 0, bank0.
REQ-036 frame_done with frame_valid=0 -> no state change, rd_bank unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, sample/complex word types, writer
// states and the bit-reversal helper also used by the FFT address generator.
package fft_pkg;

  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int WIDTH = 32;

  typedef logic signed [WIDTH/2-1:0] sample_t;
  typedef logic        [WIDTH-1:0]   cplx_t;

  typedef enum logic {FILL = 1'b0, STALL = 1'b1} wr_state_e;

  function automatic cplx_t pack(input sample_t re, input sample_t im);
    return {re, im};
  endfunction

  // Reverses the low 'bits' bits of v; bits above that come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < bits) r[bits-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_loader_if.sv
// Sample-in / frame-out bus between the audio source, the loader and the FFT
// engine. The master drives samples, read addresses and frame releases.
interface fft_bitrev_loader_if #(
  parameter int WIDTH = 32,
  parameter int LOG2N = 6
);
  logic                      sample_valid;
  logic signed [WIDTH/2-1:0] sample_in;
  logic                      sample_ready;
  logic                      frame_valid;
  logic [LOG2N-1:0]          rd_addr;
  logic [WIDTH-1:0]          rd_data;
  logic                      frame_done;
  logic                      overrun;
  logic [15:0]               drop_count;

  modport master (
    output sample_valid, sample_in, rd_addr, frame_done,
    input  sample_ready, frame_valid, rd_data, overrun, drop_count
  );

  modport slave (
    input  sample_valid, sample_in, rd_addr, frame_done,
    output sample_ready, frame_valid, rd_data, overrun, drop_count
  );
endinterface

// File: rtl/fft_frame_ram.sv
// Ping-pong frame store: one write port, one registered read port; the bank
// select is the top address bit.
module fft_frame_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_loader.sv
// Loads real audio samples into bit-reversed ping-pong frames for an in-place
// FFT, stalling when both banks are full and counting dropped samples.
module fft_bitrev_loader
  import fft_pkg::*;
#(
  parameter int N     = fft_pkg::N,
  parameter int LOG2N = fft_pkg::LOG2N,
  parameter int WIDTH = fft_pkg::WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  fft_bitrev_loader_if.slave bus
);

  wr_state_e        state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [15:0]      drop_q, drop_d;
  logic             accept, clr, last, other_free;
  logic [LOG2N:0]   waddr, raddr;

  assign bus.sample_ready = (state_q == FILL) && !rst;
  assign bus.overrun      = bus.sample_valid && (state_q != FILL) && !rst;
  assign bus.frame_valid  = full_q[rd_bank_q];
  assign bus.drop_count   = drop_q;

  assign accept = bus.sample_valid && bus.sample_ready;
  assign clr    = bus.frame_done && full_q[rd_bank_q];
  assign last   = (cnt_q == LOG2N'(N-1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    drop_d     = drop_q;
    other_free = 1'b0;
    if (clr) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    // A release in this same cycle counts as the other bank being free.
    other_free = !full_d[~wr_bank_q];
    case (state_q)
      FILL: begin
        if (accept) begin
          cnt_d = cnt_q + LOG2N'(1);
          if (last) begin
            full_d[wr_bank_q] = 1'b1;
            if (other_free) wr_bank_d = ~wr_bank_q;
            else            state_d   = STALL;
          end
        end
      end
      STALL: begin
        if (other_free) begin
          wr_bank_d = ~wr_bank_q;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (bus.overrun && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
    end
  end

  assign waddr = {wr_bank_q, LOG2N'(bitrev(16'(cnt_q), LOG2N))};
  assign raddr = {rd_bank_q, bus.rd_addr};

  fft_frame_ram #(
    .WIDTH (WIDTH),
    .AW    (LOG2N + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (waddr),
    .wdata ({bus.sample_in, {(WIDTH/2){1'b0}}}),
    .raddr (raddr),
    .rdata (bus.rd_data)
  );

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Bench for fft_bitrev_loader: directed frame/stall/reset sequences, a table of
// read-back vectors and randomized traffic against a frame-level model.
module tb_fft_bitrev_loader;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  fft_bitrev_loader_if #(.WIDTH(32), .LOG2N(6)) bus ();

  fft_bitrev_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: two frames of memory, per-bank full flags, pointers.
  logic [31:0] m_mem [0:127];
  bit          m_full [2];
  int          m_wr, m_rd, m_cnt, m_drop;
  bit          m_wait;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [6];

  function automatic int brev6(input int v);
    int r = 0;
    for (int i = 0; i < 6; i++)
      if (((v >> i) & 1) != 0) r = r | (1 << (5 - i));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_wr = 0; m_rd = 0; m_cnt = 0; m_drop = 0; m_wait = 0;
  endtask

  // One clock: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input bit r, input bit sv, input logic [15:0] s, input bit fd,
                       input logic [5:0] a);
    bit          acc, drop, clr, have_rd;
    logic [31:0] exp_rd;
    bit          nf [2];
    rst = r; bus.sample_valid = sv; bus.sample_in = s; bus.frame_done = fd; bus.rd_addr = a;
    #1;
    chk("sample_ready", 32'(bus.sample_ready), 32'(!m_wait && !r));
    chk("overrun", 32'(bus.overrun), 32'(sv && m_wait && !r));
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_full[m_rd]));
    have_rd = m_full[m_rd] && !r;
    exp_rd  = m_mem[m_rd*64 + int'(a)];
    if (r) model_reset();
    else begin
      acc  = sv && !m_wait;
      drop = sv && m_wait;
      clr  = fd && m_full[m_rd];
      nf[0] = m_full[0]; nf[1] = m_full[1];
      if (clr) nf[m_rd] = 0;
      if (acc) begin
        m_mem[m_wr*64 + brev6(m_cnt)] = {s, 16'h0000};
        if (m_cnt == 63) begin
          m_cnt = 0;
          nf[m_wr] = 1;
          if (!nf[1-m_wr]) m_wr = 1 - m_wr;
          else             m_wait = 1;
        end else m_cnt++;
      end else if (m_wait && !nf[1-m_wr]) begin
        m_wr = 1 - m_wr;
        m_wait = 0;
      end
      m_full[0] = nf[0]; m_full[1] = nf[1];
      if (clr) m_rd = 1 - m_rd;
      if (drop && m_drop < 65535) m_drop++;
    end
    @(posedge clk);
    #1;
    if (r)            chk("rd_data_rst", bus.rd_data, 32'h0);
    else if (have_rd) chk("rd_data", bus.rd_data, exp_rd);
    chk("drop_count", 32'(bus.drop_count), 32'(m_drop));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'd32, 32'h0001_0000};
    vecs[1] = '{6'd1,  32'h0020_0000};
    vecs[2] = '{6'd0,  32'h0000_0000};
    vecs[3] = '{6'd63, 32'h003F_0000};
    vecs[4] = '{6'd24, 32'h0006_0000};
    vecs[5] = '{6'd2,  32'h0010_0000};

    rst = 1'b1; bus.sample_valid = 0; bus.sample_in = '0; bus.frame_done = 0; bus.rd_addr = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 16'h7FFF, 1, 0);
    chk("rst_frame_valid", 32'(bus.frame_valid), 32'h0);
    chk("rst_drop_count", 32'(bus.drop_count), 32'h0);
    chk("rst_rd_data", bus.rd_data, 32'h0);
    chk("rst_ready", 32'(bus.sample_ready), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);

    // First frame k=0..63, then table-driven readback
    for (int k = 0; k < 64; k++) cycle(0, 1, 16'(k), 0, 0);
    chk("frame1_valid", 32'(bus.frame_valid), 32'h1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, vecs[i].addr);
      chk("frame1_read", bus.rd_data, vecs[i].exp);
    end

    // Second frame fills bank1, then three overruns
    for (int k = 0; k < 64; k++) cycle(0, 1, 16'(100 + k), 0, 0);
    chk("stall_ready", 32'(bus.sample_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      bus.sample_valid = 1; #1;
      chk("stall_overrun", 32'(bus.overrun), 32'h1);
      cycle(0, 1, 16'h5555, 0, 0);
    end
    chk("drop_count_3", 32'(bus.drop_count), 32'd3);
    cycle(0, 0, 0, 0, 0);

    // frame_done while stalled
    cycle(0, 0, 0, 1, 0);
    chk("after_done_fv", 32'(bus.frame_valid), 32'h1);
    chk("after_done_ready", 32'(bus.sample_ready), 32'h1);
    cycle(0, 0, 0, 0, 6'd32);
    chk("bank1_read", bus.rd_data, 32'h0065_0000);

    // Last sample coincides with frame_done: no stall
    for (int k = 0; k < 63; k++) cycle(0, 1, 16'(200 + k), 0, 0);
    cycle(0, 1, 16'(263), 1, 0);
    chk("coincide_ready", 32'(bus.sample_ready), 32'h1);
    chk("coincide_fv", 32'(bus.frame_valid), 32'h1);
    cycle(0, 0, 0, 0, 6'd1);
    chk("coincide_read", bus.rd_data, 32'h00E8_0000);

    // Reset mid-frame, then frame_done with no frame is ignored
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) cycle(0, 1, 16'(300 + k), 0, 0);
    cycle(1, 1, 16'h4444, 0, 0);
    chk("midrst_fv", 32'(bus.frame_valid), 32'h0);
    chk("midrst_drop", 32'(bus.drop_count), 32'h0);
    cycle(0, 1, 16'h1234, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk("ignored_done_fv", 32'(bus.frame_valid), 32'h0);
    for (int k = 1; k < 64; k++) cycle(0, 1, 16'(k), 0, 0);
    cycle(0, 0, 0, 0, 6'd0);
    chk("midrst_addr0", bus.rd_data, 32'h1234_0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 600) == 0, ($urandom % 4) != 0, 16'($urandom),
            ($urandom % 40) == 0, 6'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
